game_compositor: RTL and testbench

- Parametrised successor to the top-level pixel-priority mux and win/lose flags.
- Combines N ghost layers with pac, maze, food and win/lose screens into one registered RGB stream for video_driver.
- Owns the game-state FSM: IDLE/PLAY/RESPAWN/WIN/LOSE, a lives counter, and N-way ghost collision detection sampled once per game tick.
- Sits between the sprite/maze/food generators and video_driver; feeds respawn requests back to pacMan/ghost instances.

---
 rtl/game_compositor.sv | 135 +++++++++++++
 tb/tb_game_compositor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/game_compositor.sv
// game_compositor: N-ghost pixel-priority compositor with game-state FSM, lives and collision detection.
// Optional GAME_COMPOSITOR_BLINK_EN blinks the pac layer while in RESPAWN.
module game_compositor #(
    parameter int NUM_GHOSTS    = 4,
    parameter int LIVES         = 3,
    parameter int HIT_DIST      = 2,
    parameter int RESPAWN_TICKS = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     tick_i,
    input  logic                     start_i,
    input  logic                     food_done_i,
    input  logic [9:0]               xPacLoc_i,
    input  logic [8:0]               yPacLoc_i,
    input  logic [10*NUM_GHOSTS-1:0] xGhost_i,
    input  logic [9*NUM_GHOSTS-1:0]  yGhost_i,
    input  logic [23:0]              rgb_pac_i,
    input  logic [23:0]              rgb_maze_i,
    input  logic [23:0]              rgb_food_i,
    input  logic [23:0]              rgb_win_i,
    input  logic [23:0]              rgb_lose_i,
    input  logic [24*NUM_GHOSTS-1:0] rgb_ghost_i,
    output logic [7:0]               r_o,
    output logic [7:0]               g_o,
    output logic [7:0]               b_o,
    output logic [2:0]               state_o,
    output logic [3:0]               lives_o,
    output logic                     gamewin_o,
    output logic                     gamelose_o,
    output logic                     respawn_req_o,
    output logic                     hit_o
);
    localparam logic [2:0] IDLE = 3'd0, PLAY = 3'd1, RESPAWN = 3'd2, WIN = 3'd3, LOSE = 3'd4;
    localparam int CW = (RESPAWN_TICKS > 4) ? $clog2(RESPAWN_TICKS) : 2;

    logic [2:0]    state_q, state_d;
    logic [3:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   pix_q, pix_d;
    logic          rsp_q, rsp_d, hit_q, hit_d;
    logic          collide, pac_on;
    logic [10:0]   dx, adx;
    logic [9:0]    dy, ady;

`ifdef GAME_COMPOSITOR_BLINK_EN
    assign pac_on = |rgb_pac_i && !(state_q == RESPAWN && cnt_q[1]);
`else
    assign pac_on = |rgb_pac_i;
`endif

    // Differences are widened by one bit so they never wrap before the absolute value.
    always_comb begin
        collide = 1'b0;
        dx = '0;
        dy = '0;
        adx = '0;
        ady = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            dx = {1'b0, xPacLoc_i} - {1'b0, xGhost_i[10*i +: 10]};
            dy = {1'b0, yPacLoc_i} - {1'b0, yGhost_i[9*i +: 9]};
            adx = dx[10] ? -dx : dx;
            ady = dy[9] ? -dy : dy;
            collide = collide | (adx <= 11'(HIT_DIST) && ady <= 10'(HIT_DIST));
        end
    end

    // Lowest-priority layers first so later assignments win; absent food leaves black.
    always_comb begin
        pix_d = |rgb_maze_i ? rgb_maze_i : rgb_food_i;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--)
            pix_d = |rgb_ghost_i[24*i +: 24] ? rgb_ghost_i[24*i +: 24] : pix_d;
        pix_d = pac_on ? rgb_pac_i : pix_d;
        pix_d = (state_q == WIN) ? rgb_win_i : (state_q == LOSE) ? rgb_lose_i : pix_d;
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d = cnt_q;
        rsp_d = 1'b0;
        hit_d = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = PLAY;
                rsp_d = 1'b1;
            end
            PLAY: if (tick_i) begin
                if (food_done_i) state_d = WIN;
                else if (collide) begin
                    hit_d = 1'b1;
                    lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
                    state_d = (lives_d == 4'd0) ? LOSE : RESPAWN;
                    rsp_d = (lives_d != 4'd0);
                    cnt_d = '0;
                end
            end
            RESPAWN: if (tick_i) begin
                state_d = (cnt_q == CW'(RESPAWN_TICKS - 1)) ? PLAY : RESPAWN;
                cnt_d = (cnt_q == CW'(RESPAWN_TICKS - 1)) ? '0 : cnt_q + 1'b1;
            end
            WIN, LOSE: if (start_i) begin
                state_d = IDLE;
                lives_d = 4'(LIVES);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            lives_q <= 4'(LIVES);
            cnt_q <= '0;
            pix_q <= '0;
            rsp_q <= 1'b0;
            hit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            cnt_q <= cnt_d;
            pix_q <= pix_d;
            rsp_q <= rsp_d;
            hit_q <= hit_d;
        end
    end

    assign {r_o, g_o, b_o} = pix_q;
    assign state_o = state_q;
    assign lives_o = lives_q;
    assign gamewin_o = (state_q == WIN);
    assign gamelose_o = (state_q == LOSE);
    assign respawn_req_o = rsp_q;
    assign hit_o = hit_q;
endmodule

// File: tb/tb_game_compositor.sv
// tb_game_compositor: scoreboard bench for game_compositor (pixel priority, FSM, lives, collisions).
module tb_game_compositor;
    localparam int NG = 4;

    logic        clk = 1'b0, reset_ni = 1'b0, tick = 1'b0, start = 1'b0, food_done = 1'b0;
    logic [9:0]  xp = '0, gx[NG];
    logic [8:0]  yp = '0, gy[NG];
    logic [23:0] pac = '0, maze = '0, food = '0, win = 24'h00FFFF, lose = 24'hAA55AA, gc[NG];
    logic [7:0]  r, g, b;
    logic [2:0]  state;
    logic [3:0]  lives;
    logic        gamewin, gamelose, respawn_req, hit;
    logic [23:0] exp_q[$];
    int          exp_st = 0;
    int          n_chk = 0, n_err = 0;

    game_compositor #(.NUM_GHOSTS(NG)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .tick_i(tick), .start_i(start), .food_done_i(food_done),
        .xPacLoc_i(xp), .yPacLoc_i(yp),
        .xGhost_i({gx[3], gx[2], gx[1], gx[0]}), .yGhost_i({gy[3], gy[2], gy[1], gy[0]}),
        .rgb_pac_i(pac), .rgb_maze_i(maze), .rgb_food_i(food), .rgb_win_i(win), .rgb_lose_i(lose),
        .rgb_ghost_i({gc[3], gc[2], gc[1], gc[0]}),
        .r_o(r), .g_o(g), .b_o(b), .state_o(state), .lives_o(lives),
        .gamewin_o(gamewin), .gamelose_o(gamelose), .respawn_req_o(respawn_req), .hit_o(hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference priority model, written as a plain chain over the bench's own layer values.
    function automatic logic [23:0] model();
        if (exp_st == 3) return win;
        if (exp_st == 4) return lose;
        if (pac != 0) return pac;
        for (int i = 0; i < NG; i++) if (gc[i] != 0) return gc[i];
        if (maze != 0) return maze;
        if (food != 0) return food;
        return 24'h0;
    endfunction

    task automatic push_exp();
        exp_q.push_back(model());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) check("pixel", {8'h0, r, g, b}, {8'h0, exp_q.pop_front()});
    endtask

    task automatic tick_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic ghosts_far();
        for (int i = 0; i < NG; i++) begin
            gx[i] = 10'd500;
            gy[i] = 9'd400;
        end
    endtask

    initial begin
        ghosts_far();
        for (int i = 0; i < NG; i++) gc[i] = '0;
        pac = 24'hFFFFFF;
        tick = 1'b1;
        step();
        step();
        tick = 1'b0;
        check("rst_rgb", {8'h0, r, g, b}, 32'h0);
        check("rst_state", state, 0);
        check("rst_lives", lives, 3);
        check("rst_pulses", {gamewin, gamelose, respawn_req, hit}, 0);
        reset_ni = 1'b1;

        pac = 0; maze = 24'h0000FF; food = 24'h00FF00;
        push_exp(); step();
        start = 1'b1; step(); start = 1'b0; exp_st = 1;
        check("start_state", state, 1);
        check("start_rsp", respawn_req, 1);
        step();
        check("rsp_pulse_end", respawn_req, 0);

        gc[1] = 24'hFF0000; gc[2] = 24'h00FF00;
        push_exp(); step();
        pac = 24'hFFFF00; push_exp(); step();
        pac = 0; gc[1] = 0; gc[2] = 0; maze = 0; food = 24'h123456; push_exp(); step();
        food = 0; push_exp(); step();
        gc[0] = 24'h010203; gc[1] = 24'h0A0B0C; maze = 24'h0000FF; push_exp(); step();
        gc[3] = 24'h808080; gc[0] = 0; gc[1] = 0; push_exp(); step();

        xp = 10'd40; yp = 9'd30; gx[3] = 10'd42; gy[3] = 9'd28;
        tick_step();
        check("col_hit", hit, 1);
        check("col_lives", lives, 2);
        check("col_state", state, 2);
        check("col_rsp", respawn_req, 1);
        exp_st = 2;
        food_done = 1'b1;
        for (int i = 0; i < 15; i++) tick_step();
        check("rsp_hold_state", state, 2);
        check("rsp_hold_lives", lives, 2);
        food_done = 1'b0; ghosts_far();
        tick_step();
        check("rsp_done", state, 1);
        exp_st = 1;

        gx[0] = 10'd43; gy[0] = 9'd30; tick_step();
        check("miss_dx3", {hit, state}, {1'b0, 3'd1});
        gx[0] = 10'd40; gy[0] = 9'd33; tick_step();
        check("miss_dy3", {hit, state}, {1'b0, 3'd1});
        xp = 0; yp = 0; gx[0] = 10'd1022; gy[0] = 0; tick_step();
        check("nowrap_x", {hit, state}, {1'b0, 3'd1});
        gx[0] = 0; gy[0] = 9'd510; tick_step();
        check("nowrap_y", {hit, state}, {1'b0, 3'd1});
        gx[0] = 10'd2; gy[0] = 9'd2; tick_step();
        check("edge_hit", {hit, lives, state}, {1'b1, 4'd1, 3'd2});
        ghosts_far();
        for (int i = 0; i < 16; i++) tick_step();
        check("rsp2_done", state, 1);

        gx[0] = 10'd1; gy[0] = 9'd1; tick_step();
        check("lose_state", state, 4);
        check("lose_flags", {gamelose, gamewin, hit, respawn_req}, 4'b1010);
        check("lose_lives", lives, 0);
        exp_st = 4; pac = 24'h111111; push_exp(); step();
        tick_step();
        check("lose_sticky", {state, lives}, {3'd4, 4'd0});

        start = 1'b1; step(); start = 1'b0;
        check("restart_idle", {state, lives, gamelose}, {3'd0, 4'd3, 1'b0});
        exp_st = 0;
        start = 1'b1; step(); start = 1'b0;
        check("restart_play", {state, respawn_req}, {3'd1, 1'b1});
        exp_st = 1;

        gx[0] = 0; gy[0] = 0; food_done = 1'b1; tick_step(); food_done = 1'b0;
        check("win_state", {state, gamewin, gamelose}, {3'd3, 1'b1, 1'b0});
        check("win_lives_hit", {lives, hit}, {4'd3, 1'b0});
        exp_st = 3; push_exp(); step();
        start = 1'b1; step(); start = 1'b0;
        check("win_restart", {state, lives}, {3'd0, 4'd3});
        exp_st = 0;

        start = 1'b1; step(); start = 1'b0;
        tick_step();
        check("mid_rsp_enter", {state, lives}, {3'd2, 4'd2});
        for (int i = 0; i < 3; i++) tick_step();
        reset_ni = 1'b0; tick = 1'b1; step(); tick = 1'b0;
        check("mid_rsp_reset", {state, lives, respawn_req, hit}, {3'd0, 4'd3, 1'b0, 1'b0});
        check("mid_rsp_rgb", {8'h0, r, g, b}, 32'h0);
        reset_ni = 1'b1;
        step();
        check("post_reset_idle", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
